// File: rtl/sid_bus_master.sv
// Bus master for a SID-style peripheral: generates PHI2 from clk and runs one
// read or write per PHI2 period from a one-entry request buffer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no bus cycle in progress; chip select released
// ST_XFER | bus cycle running from cnt==1 through cnt==0 of the next period
module sid_bus_master #(
    parameter int AW   = 5,
    parameter int HALF = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [7:0]    req_wdata,
    output logic          rsp_valid,
    output logic [7:0]    rsp_rdata,
    output logic          phi2_fall,
    output logic          bus_phi2,
    output logic [AW-1:0] bus_a,
    output logic          bus_r_wn,
    output logic          bus_csn,
    output logic [7:0]    bus_d_o,
    output logic          bus_d_oe,
    input  logic [7:0]    bus_d_i
);

    localparam int CW = $clog2(2 * HALF);
    localparam logic [CW-1:0] CNT_MAX = CW'(2 * HALF - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_HALF_M1 = CW'(HALF - 1);

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phi2_q, phi2_d;
    logic          fall_q, fall_d;

    logic          pend_valid_q, pend_valid_d;
    logic          pend_we_q, pend_we_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]    pend_wdata_q, pend_wdata_d;

    logic          xfer_we_q, xfer_we_d;
    logic [7:0]    xfer_wdata_q, xfer_wdata_d;

    logic          csn_q, csn_d;
    logic          r_wn_q, r_wn_d;
    logic [AW-1:0] a_q, a_d;
    logic [7:0]    d_o_q, d_o_d;
    logic          d_oe_q, d_oe_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic launch;

    assign req_ready = ~pend_valid_q;
    assign accept    = req_valid & ~pend_valid_q;
    // Launch only from an entry that was already pending when cnt==0 began.
    assign launch    = pend_valid_q & (cnt_q == '0);

    always_comb begin
        cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        phi2_d       = (cnt_d >= CNT_HALF);
        fall_d       = (cnt_d == '0);

        pend_valid_d = pend_valid_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;

        state_d      = state_q;
        xfer_we_d    = xfer_we_q;
        xfer_wdata_d = xfer_wdata_q;
        csn_d        = csn_q;
        r_wn_d       = r_wn_q;
        a_d          = a_q;
        d_o_d        = d_o_q;
        d_oe_d       = d_oe_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;

        if (accept) begin
            pend_valid_d = 1'b1;
            pend_we_d    = req_we;
            pend_addr_d  = req_addr;
            pend_wdata_d = req_wdata;
        end else if (launch) begin
            pend_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d      = ST_XFER;
                    xfer_we_d    = pend_we_q;
                    xfer_wdata_d = pend_wdata_q;
                    csn_d        = 1'b0;
                    a_d          = pend_addr_q;
                    r_wn_d       = ~pend_we_q;
                end
            end
            ST_XFER: begin
                if ((cnt_q == CNT_HALF_M1) && xfer_we_q) begin
                    d_oe_d = 1'b1;
                    d_o_d  = xfer_wdata_q;
                end
                if ((cnt_q == CNT_MAX) && !xfer_we_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus_d_i;
                end
                // cnt==0 is the last clk of the cycle; write data is held
                // through it and released on the edge that ends it.
                if (cnt_q == '0) begin
                    d_oe_d = 1'b0;
                    if (launch) begin
                        xfer_we_d    = pend_we_q;
                        xfer_wdata_d = pend_wdata_q;
                        a_d          = pend_addr_q;
                        r_wn_d       = ~pend_we_q;
                    end else begin
                        state_d = ST_IDLE;
                        csn_d   = 1'b1;
                        r_wn_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                csn_d   = 1'b1;
                r_wn_d  = 1'b1;
                d_oe_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            phi2_q       <= 1'b0;
            fall_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            xfer_we_q    <= 1'b0;
            xfer_wdata_q <= '0;
            csn_q        <= 1'b1;
            r_wn_q       <= 1'b1;
            a_q          <= '0;
            d_o_q        <= '0;
            d_oe_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phi2_q       <= phi2_d;
            fall_q       <= fall_d;
            pend_valid_q <= pend_valid_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_wdata_q <= pend_wdata_d;
            xfer_we_q    <= xfer_we_d;
            xfer_wdata_q <= xfer_wdata_d;
            csn_q        <= csn_d;
            r_wn_q       <= r_wn_d;
            a_q          <= a_d;
            d_o_q        <= d_o_d;
            d_oe_q       <= d_oe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign bus_phi2  = phi2_q;
    assign phi2_fall = fall_q;
    assign bus_csn   = csn_q;
    assign bus_r_wn  = r_wn_q;
    assign bus_a     = a_q;
    assign bus_d_o   = d_o_q;
    assign bus_d_oe  = d_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/sid_bus_master.md
SID_BUS_MASTER -- requirements
Module: sid_bus_master

Interface
REQ-001 SHALL have parameter AW, default 5: width of the SID register address.
REQ-002 SHALL have parameter HALF, default 12, legal values 3 or more: clk cycles per PHI2 half-period.
REQ-003 SHALL have port clk, input, 1 bit: system clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a transaction request is offered.
REQ-006 SHALL have port req_ready, output, 1 bit: a request can be accepted.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, AW bits: register address.
REQ-009 SHALL have port req_wdata, input, 8 bits: write data.
REQ-010 SHALL have port rsp_valid, output, 1 bit: one-clk pulse qualifying read data.
REQ-011 SHALL have port rsp_rdata, output, 8 bits: read data.
REQ-012 SHALL have port phi2_fall, output, 1 bit: one-clk pulse per PHI2 period.
REQ-013 SHALL have port bus_phi2, output, 1 bit: PHI2 clock to the SID.
REQ-014 SHALL have port bus_a, output, AW bits: address pins.
REQ-015 SHALL have port bus_r_wn, output, 1 bit: R/W pin (1 = read).
REQ-016 SHALL have port bus_csn, output, 1 bit: chip select, active low.
REQ-017 SHALL have port bus_d_o, output, 8 bits: data out to the pad drivers.
REQ-018 SHALL have port bus_d_oe, output, 1 bit: data output enable.
REQ-019 SHALL have port bus_d_i, input, 8 bits: data in from the pads.

Function
REQ-020 SHALL run a free-running phase counter cnt over 0..2*HALF-1 that wraps to 0.
REQ-021 SHALL register bus_phi2 as 1 when cnt is in HALF..2*HALF-1 and 0 otherwise; the PHI2 falling edge is the wrap 2*HALF-1 -> 0.
REQ-022 SHALL assert phi2_fall during the clk where cnt==0, and only then.
REQ-023 SHALL hold a one-entry pending register; req_ready = ~pending_valid (combinational).
REQ-024 SHALL capture req_we, req_addr and req_wdata into pending on the clk edge where req_valid & req_ready.
REQ-025 SHALL launch the pending transaction on the edge that ends a cnt==0 clk while pending_valid is 1, clearing pending_valid on that edge.
REQ-026 A request accepted during a cnt==0 clk SHALL NOT launch in that period; it launches at the next cnt==0 edge.
REQ-027 Once a transaction launches, from cnt==1 bus_csn=0, bus_a=addr and bus_r_wn=~we SHALL hold until the edge ending cnt==0 of the next period (2*HALF clks).
REQ-028 A write SHALL drive bus_d_o=wdata and bus_d_oe=1 from cnt==HALF through cnt==0 of the next period (HALF+1 clks); this is 1 clk of data hold after the PHI2 fall.
REQ-029 A read SHALL keep bus_d_oe=0 and SHALL register bus_d_i at the end of the cnt==2*HALF-1 clk into rsp_rdata.
REQ-030 rsp_valid SHALL pulse for 1 clk during cnt==0 after a read cycle; rsp_rdata SHALL hold its value until the next read.
REQ-031 If pending_valid is 1 at the end of a cycle's final cnt==0 clk, the next transaction SHALL start at cnt==1 with bus_csn continuously 0; bus_a and bus_r_wn SHALL update at cnt==1.
REQ-032 With no launch, the following SHALL hold at cnt==1 onward: bus_csn=1, bus_r_wn=1, bus_d_oe=0; bus_a and bus_d_o SHALL keep their last values.
REQ-033 All bus_* outputs, rsp_valid and phi2_fall SHALL be registered (no combinational path from req_* to bus pins).

Reset
REQ-034 While rst=1 the block SHALL hold: cnt=0, bus_phi2=0, phi2_fall=0, bus_csn=1, bus_r_wn=1, bus_a=0, bus_d_o=0, bus_d_oe=0, pending_valid=0 (req_ready=1), rsp_valid=0, rsp_rdata=0.
REQ-035 Reset mid-transaction SHALL discard the transaction with no rsp_valid; after release cnt SHALL start at 0.

Verification (HALF=4, period 8 clk)
REQ-036 Release rst, idle -> bus_phi2 low 4 clks / high 4 clks repeating; phi2_fall high exactly at cnt==0; bus_csn stays 1.
REQ-037 Write addr 0x18 data 0x0F accepted at cnt==3 -> from next cnt==1, bus_csn=0, bus_r_wn=0, bus_a=0x18 for 8 clks; bus_d_oe=1 and bus_d_o=0x0F during cnt 4..7 and the following cnt 0; no rsp_valid.
REQ-038 Read addr 0x1B with bus_d_i=0xA5 -> bus_r_wn=1, bus_d_oe=0; rsp_valid pulses for 1 clk at the cnt==0 ending the cycle with rsp_rdata=0xA5.
REQ-039 Two writes offered back-to-back -> req_ready=0 until the first launches; bus_csn stays 0 for 16 consecutive clks; bus_a changes at cnt==1 of the second period.
REQ-040 Request accepted at cnt==0 -> no launch at that edge; launch at cnt==1 of the following period.
REQ-041 rst asserted at cnt==5 of a write -> bus_csn=1, bus_d_oe=0 and bus_phi2=0 immediately; no rsp_valid; req_ready=1 after release.
